// File: rtl/intr_frame_assembler.sv
// Assembles SYNC/ADDR/D2/D1/D0/CSUM byte frames from the host interrupt link into
// register commands, discarding frames with bad checksum, reserved bits or idle timeout.
module intr_frame_assembler #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic        sysClk,
   input  logic        reset,
   input  logic [7:0]  rx_byte,
   input  logic        rx_byte_valid,
   output logic [7:0]  reg_addr,
   output logic [16:0] reg_data,
   output logic        reg_input_valid,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic        busy
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_D2,
      ST_D1,
      ST_D0,
      ST_CSUM
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] idle_cnt_reg;
   logic [CW-1:0] idle_cnt_inc;
   logic [7:0]    xor_reg;
   logic [7:0]    addr_reg;
   logic [7:0]    d1_reg;
   logic [7:0]    d0_reg;
   logic          d16_reg;
   logic          bad_reg;
   logic          timeout;

   assign busy = (state_reg != ST_IDLE);

   always_ff @(posedge sysClk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A byte strobe always takes priority over the idle timeout in the same cycle.
   always_comb begin
      state_next   = state_reg;
      timeout      = 1'b0;
      idle_cnt_inc = (idle_cnt_reg == CNT_LIMIT) ? idle_cnt_reg : idle_cnt_reg + 1'b1;
      if (rx_byte_valid) begin
         case (state_reg)
            ST_IDLE: if (rx_byte == SYNC_BYTE) state_next = ST_ADDR;
            ST_ADDR: state_next = ST_D2;
            ST_D2:   state_next = ST_D1;
            ST_D1:   state_next = ST_D0;
            ST_D0:   state_next = ST_CSUM;
            ST_CSUM: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
         endcase
      end else if (state_reg != ST_IDLE && idle_cnt_inc == CNT_LIMIT) begin
         timeout    = 1'b1;
         state_next = ST_IDLE;
      end
   end

   always_ff @(posedge sysClk) begin
      if (reset) begin
         idle_cnt_reg    <= '0;
         xor_reg         <= '0;
         addr_reg        <= '0;
         d1_reg          <= '0;
         d0_reg          <= '0;
         d16_reg         <= 1'b0;
         bad_reg         <= 1'b0;
         reg_addr        <= '0;
         reg_data        <= '0;
         reg_input_valid <= 1'b0;
         frame_err       <= 1'b0;
         err_code        <= 2'b00;
      end else begin
         reg_input_valid <= 1'b0;
         frame_err       <= 1'b0;

         if (state_reg == ST_IDLE || rx_byte_valid || timeout) begin
            idle_cnt_reg <= '0;
         end else begin
            idle_cnt_reg <= idle_cnt_inc;
         end

         if (timeout) begin
            frame_err <= 1'b1;
            err_code  <= 2'b11;
         end

         if (rx_byte_valid) begin
            case (state_reg)
               ST_IDLE: begin
                  if (rx_byte == SYNC_BYTE) begin
                     xor_reg <= '0;
                     bad_reg <= 1'b0;
                  end
               end
               ST_ADDR: begin
                  addr_reg <= rx_byte;
                  xor_reg  <= xor_reg ^ rx_byte;
               end
               ST_D2: begin
                  d16_reg <= rx_byte[0];
                  bad_reg <= bad_reg | (|rx_byte[7:1]);
                  xor_reg <= xor_reg ^ rx_byte;
               end
               ST_D1: begin
                  d1_reg  <= rx_byte;
                  xor_reg <= xor_reg ^ rx_byte;
               end
               ST_D0: begin
                  d0_reg  <= rx_byte;
                  xor_reg <= xor_reg ^ rx_byte;
               end
               ST_CSUM: begin
                  // Reserved-bit failure outranks a checksum mismatch.
                  if (bad_reg) begin
                     frame_err <= 1'b1;
                     err_code  <= 2'b10;
                  end else if (rx_byte != xor_reg) begin
                     frame_err <= 1'b1;
                     err_code  <= 2'b01;
                  end else begin
                     reg_addr        <= addr_reg;
                     reg_data        <= {d16_reg, d1_reg, d0_reg};
                     reg_input_valid <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/intr_frame_assembler.md
INTR_FRAME_ASSEMBLER -- requirements
Module: intr_frame_assembler

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, start-of-frame marker.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, maximum idle sysClk cycles between bytes inside a frame.
REQ-003 sysClk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_byte  input  8  byte from the host interrupt interface.
REQ-006 rx_byte_valid  input  1  rx_byte qualifier, one-cycle strobe per byte.
REQ-007 reg_addr  output  8  register address of the last good frame.
REQ-008 reg_data  output  17  register data of the last good frame.
REQ-009 reg_input_valid  output  1  one-cycle strobe: reg_addr/reg_data carry a new command.
REQ-010 frame_err  output  1  one-cycle strobe: frame discarded.
REQ-011 err_code  output  2  cause of the last discard: 01 checksum, 10 reserved bits, 11 timeout; valid while frame_err is high, held otherwise.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 Frame byte order: SYNC_BYTE, ADDR, D2, D1, D0, CSUM.
REQ-014 D2 bit0 = data[16]; D2 bits7:1 are reserved and must be 0.
REQ-015 D1 = data[15:8]; D0 = data[7:0].
REQ-016 CSUM = ADDR ^ D2 ^ D1 ^ D0 (8-bit XOR; SYNC_BYTE excluded).
REQ-017 FSM states: IDLE, ADDR, D2, D1, D0, CSUM; one state advance per rx_byte_valid, no advance otherwise.
REQ-018 IDLE: SYNC_BYTE -> ADDR; any other byte is dropped silently (no frame_err).
REQ-019 In ADDR, a byte equal to SYNC_BYTE is taken as the address, not as a resync.
REQ-020 Running XOR clears on entry to ADDR and accumulates ADDR..D0.
REQ-021 Nonzero reserved bits in D2 set a sticky bad flag; the frame still runs to CSUM.
REQ-022 CSUM byte accepted: the FSM returns to IDLE.
REQ-023 Good frame (checksum match, bad flag clear): on the next cycle, reg_addr/reg_data update and reg_input_valid pulses for exactly 1 cycle.
REQ-024 Reserved-bit failure: frame_err pulses with err_code=10 and reg_* are unchanged.
REQ-025 Checksum failure with bad flag clear: frame_err pulses with err_code=01 and reg_* are unchanged.
REQ-026 When both failures apply, err_code=10.
REQ-027 Latency: CSUM strobe at cycle N gives reg_input_valid/frame_err at cycle N+1.
REQ-028 reg_addr/reg_data stay stable between good frames.
REQ-029 Timeout counter, outside IDLE only: clears on every rx_byte_valid and increments otherwise, saturating.
REQ-030 When the counter reaches TIMEOUT_CYCLES: the FSM returns to IDLE, frame_err pulses with err_code=11, and partial data is discarded.
REQ-031 If a byte strobe and the timeout fall in the same cycle, the byte wins: no timeout and the counter clears.
REQ-032 A byte arriving in the cycle after a timeout is processed from IDLE.
REQ-033 reg_input_valid and frame_err are never high in the same cycle.
REQ-034 Back-to-back frames with rx_byte_valid high every cycle are accepted without loss; sustained throughput is 1 byte/cycle.

Reset
REQ-035 Reset values: FSM=IDLE, reg_addr=0, reg_data=0, reg_input_valid=0, frame_err=0, err_code=00, busy=0; XOR accumulator, bad flag and timeout counter are cleared.
REQ-036 Reset asserted mid-frame aborts the frame with no frame_err and no reg_* update; bytes strobed during reset are ignored.

Verification
REQ-037 Stimulus A5 10 01 23 45 77 -> reg_input_valid 1 cycle; reg_addr=0x10, reg_data=0x12345.
REQ-038 Stimulus A5 10 01 23 45 78 -> frame_err with err_code=01; reg_* hold their previous values.
REQ-039 Stimulus A5 10 03 23 45 75 (checksum correct) -> frame_err with err_code=10.
REQ-040 Stimulus A5 10 01, then idle for TIMEOUT_CYCLES -> frame_err with err_code=11, busy=0; a following A5 20 00 00 01 21 -> reg_addr=0x20, reg_data=0x00001.
REQ-041 Stimulus 00 FF A5 A5 00 00 00 A5 -> the leading bytes are dropped silently; reg_addr=0xA5, reg_data=0.
REQ-042 Reset asserted after A5 10 01, then A5 10 01 23 45 77 -> a single good frame; no frame_err at any point.
